output_port_allocator: RTL

- Wormhole switch allocator for one router output port, shared by the five input ports L, N, E, W, S (index 0..4).
- Grants the port to one input from header flit to tail flit, using round-robin priority.
- Gates each flit transfer on a downstream credit counter.
- Frees a stalled grant with a watchdog timeout, so one blocked packet cannot hold the crossbar output.

---
 rtl/output_port_allocator_pkg.sv | 27 ++
 rtl/output_port_allocator_rr_priority_picker.sv | 35 +++
 rtl/output_port_allocator.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/output_port_allocator_pkg.sv
// rtl/output_port_allocator_pkg.sv - shared constants, state encoding and helpers for the output port allocator
package output_port_allocator_pkg;

    localparam int NPORTS = 5;

    localparam logic [2:0] FLIT_HEADER = 3'b001;
    localparam logic [2:0] FLIT_BODY   = 3'b010;
    localparam logic [2:0] FLIT_TAIL   = 3'b100;

    localparam logic [2:0] PORT_L = 3'd0;
    localparam logic [2:0] PORT_N = 3'd1;
    localparam logic [2:0] PORT_E = 3'd2;
    localparam logic [2:0] PORT_W = 3'd3;
    localparam logic [2:0] PORT_S = 3'd4;

    // Two-bit encoding so that an upset into an unused code is recoverable.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01
    } state_t;

    // Port after p in round-robin order, wrapping S back to L.
    function automatic logic [2:0] next_port(input logic [2:0] p);
        return (p >= PORT_S) ? PORT_L : p + 3'd1;
    endfunction

endpackage

// File: rtl/output_port_allocator_rr_priority_picker.sv
// rtl/output_port_allocator_rr_priority_picker.sv - combinational round-robin pick of the first eligible port
module rr_priority_picker
    import output_port_allocator_pkg::*;
(
    input  logic [NPORTS-1:0] eligible,
    input  logic [2:0]        rr_ptr,
    output logic [NPORTS-1:0] pick,
    output logic [2:0]        pick_idx,
    output logic              found
);

    logic [3:0] cand;

    // Scan rr_ptr, rr_ptr+1, ... modulo NPORTS and keep the first eligible port.
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        cand     = '0;
        for (int k = 0; k < NPORTS; k++) begin
            cand = {1'b0, rr_ptr} + 4'(k);
            if (cand >= 4'(NPORTS)) begin
                cand = cand - 4'(NPORTS);
            end
            if (!found && eligible[cand[2:0]]) begin
                found    = 1'b1;
                pick_idx = cand[2:0];
            end
        end
        if (found) begin
            pick = NPORTS'(1) << pick_idx;
        end
    end

endmodule

// File: rtl/output_port_allocator.sv
// rtl/output_port_allocator.sv - wormhole output port allocator with credit gating and watchdog abort
module output_port_allocator
    import output_port_allocator_pkg::*;
#(
    parameter int CREDITS = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NPORTS-1:0]     req,
    input  logic [3*NPORTS-1:0]   flit_id,
    input  logic                  credit_in,
    output logic [NPORTS-1:0]     grant,
    output logic [2:0]            sel,
    output logic                  xfer,
    output logic                  timeout,
    output logic [3:0]            credit_cnt
);

    state_t              state, state_nxt;
    logic [2:0]          owner, owner_nxt;
    logic [2:0]          rr_ptr, rr_ptr_nxt;
    logic [NPORTS-1:0]   grant_r, grant_nxt;
    logic [11:0]         wd_cnt;
    logic                wd_clr, wd_inc;

    logic [2:0]          flit_arr [NPORTS];
    logic [NPORTS-1:0]   eligible;
    logic [NPORTS-1:0]   pick;
    logic [2:0]          pick_idx;
    logic                found;
    logic [2:0]          owner_flit;

    // Split the packed flit-type bus per port and flag ports presenting a header.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NPORTS; i++) begin
            flit_arr[i] = flit_id[3*i +: 3];
            eligible[i] = req[i] && (flit_id[3*i +: 3] == FLIT_HEADER);
        end
    end

    assign owner_flit = flit_arr[owner];

    rr_priority_picker u_picker (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .pick     (pick),
        .pick_idx (pick_idx),
        .found    (found)
    );

    // Next-state, transfer gating and watchdog control.
    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        rr_ptr_nxt = rr_ptr;
        grant_nxt  = grant_r;
        xfer       = 1'b0;
        timeout    = 1'b0;
        sel        = 3'd0;
        wd_clr     = 1'b0;
        wd_inc     = 1'b0;
        case (state)
            ST_IDLE: begin
                grant_nxt = '0;
                if (found) begin
                    state_nxt = ST_BUSY;
                    owner_nxt = pick_idx;
                    grant_nxt = pick;
                    wd_clr    = 1'b1;
                end
            end
            ST_BUSY: begin
                sel  = owner;
                xfer = req[owner] && (credit_cnt != 4'd0);
                if (xfer) begin
                    // A header seen here is just another flit; only a tail releases.
                    wd_clr = 1'b1;
                    if (owner_flit == FLIT_TAIL) begin
                        state_nxt  = ST_IDLE;
                        grant_nxt  = '0;
                        rr_ptr_nxt = next_port(owner);
                    end
                end else if (wd_cnt == 12'(TIMEOUT - 1)) begin
                    timeout    = 1'b1;
                    state_nxt  = ST_IDLE;
                    grant_nxt  = '0;
                    rr_ptr_nxt = next_port(owner);
                end else begin
                    wd_inc = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    assign grant = grant_r;

    // Ownership, grant and round-robin pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            owner   <= 3'd0;
            rr_ptr  <= 3'd0;
            grant_r <= '0;
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            rr_ptr  <= rr_ptr_nxt;
            grant_r <= grant_nxt;
        end
    end

    // Downstream credit counter; returned credits beyond the buffer depth are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_cnt <= 4'(CREDITS);
        end else if (xfer && !credit_in) begin
            credit_cnt <= credit_cnt - 4'd1;
        end else if (!xfer && credit_in && (credit_cnt != 4'(CREDITS))) begin
            credit_cnt <= credit_cnt + 4'd1;
        end
    end

    // Watchdog counting stalled cycles inside a grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= 12'd0;
        end else if (wd_clr) begin
            wd_cnt <= 12'd0;
        end else if (wd_inc) begin
            wd_cnt <= wd_cnt + 12'd1;
        end
    end

endmodule
